// File: rtl/core_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grande_risco5_types (package)
// Description : Shared types for the core bus arbiter: FSM state encoding
//               and the grant selector encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package grande_risco5_types;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INSTR = 3'd1,
    DATA  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } bus_arb_state_t;

  // Which requester owns (or last owned) the memory port
  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } bus_arb_grant_t;

endpackage
`default_nettype wire

// File: rtl/core_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : core_bus_arbiter_if
// Description : Bundles the core-side fetch/data request signals and the
//               memory-side strobe/ack signals around the bus arbiter.
//               master : arbiter view (drives memory strobes and responses)
//               slave  : environment view (core requesters plus memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface core_bus_arbiter_if;

  logic        flush_bus;
  logic        instruction_request;
  logic [31:0] instruction_address;
  logic        instruction_response;
  logic [31:0] instruction_data;
  logic        data_memory_read;
  logic        data_memory_write;
  logic [31:0] data_address;
  logic [31:0] write_data;
  logic        data_memory_response;
  logic [31:0] read_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_ack;
  logic [31:0] mem_read_data;

  modport master (
    input  flush_bus,
    input  instruction_request,
    input  instruction_address,
    output instruction_response,
    output instruction_data,
    input  data_memory_read,
    input  data_memory_write,
    input  data_address,
    input  write_data,
    output data_memory_response,
    output read_data,
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_write_data,
    input  mem_ack,
    input  mem_read_data
  );

  modport slave (
    output flush_bus,
    output instruction_request,
    output instruction_address,
    input  instruction_response,
    input  instruction_data,
    output data_memory_read,
    output data_memory_write,
    output data_address,
    output write_data,
    input  data_memory_response,
    input  read_data,
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_write_data,
    output mem_ack,
    output mem_read_data
  );

endinterface
`default_nettype wire

// File: rtl/core_bus_arbiter_grant.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb_grant
// Description : Combinational grant picker for the bus arbiter. Takes the
//               eligible fetch/data requests and the previous grant.
//               BUS_ARB_ROUND_ROBIN_EN : alternate owners on contention;
//               otherwise data always wins over fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arb_grant
  import grande_risco5_types::*;
(
  input  logic           instr_req,
  input  logic           data_req,
  input  bus_arb_grant_t last_grant,
  output bus_arb_grant_t grant
);

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // On contention hand the port to whoever did not have it last
  always_comb begin
    grant = GRANT_INSTR;
    if (instr_req && data_req) begin
      grant = (last_grant == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
    end else if (data_req) begin
      grant = GRANT_DATA;
    end
  end
`else
  // History is irrelevant with fixed priority
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Data port always beats fetch
  always_comb begin
    grant = GRANT_INSTR;
    if (data_req) begin
      grant = GRANT_DATA;
    end
  end
  wire unused_instr_req = instr_req;
`endif

endmodule
`default_nettype wire

// File: rtl/core_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : core_bus_arbiter
// Description : Shares one memory port between the core fetch bus and data
//               bus. One transaction at a time: grant, access (held until
//               mem_ack), one-cycle response. Fetch flush discards an
//               in-flight fetch by draining it silently.
//               Optional macro BUS_ARB_ROUND_ROBIN_EN selects round-robin
//               arbitration instead of fixed data-over-fetch priority.
// Revision    : 1.0 - initial release
// ============================================================================
module core_bus_arbiter
  import grande_risco5_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  core_bus_arbiter_if.master   bus
);

  bus_arb_state_t state_q, state_d;
  bus_arb_grant_t last_grant_q, last_grant_d;
  bus_arb_grant_t grant;
  logic           resp_instr_q, resp_instr_d;
  logic           mem_read_q, mem_read_d;
  logic           mem_write_q, mem_write_d;
  logic [31:0]    mem_address_q, mem_address_d;
  logic [31:0]    mem_write_data_q, mem_write_data_d;
  logic [31:0]    instruction_data_q, instruction_data_d;
  logic [31:0]    read_data_q, read_data_d;

  logic           instr_eligible;
  logic           data_eligible;

  // A fetch raised together with a flush is already stale
  assign instr_eligible = bus.instruction_request & ~bus.flush_bus;
  assign data_eligible  = bus.data_memory_read | bus.data_memory_write;

  bus_arb_grant u_grant (
    .instr_req  (instr_eligible),
    .data_req   (data_eligible),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Next-state, memory strobe sequencing and response data capture
  always_comb begin
    state_d            = state_q;
    last_grant_d       = last_grant_q;
    resp_instr_d       = resp_instr_q;
    mem_read_d         = mem_read_q;
    mem_write_d        = mem_write_q;
    mem_address_d      = mem_address_q;
    mem_write_data_d   = mem_write_data_q;
    instruction_data_d = instruction_data_q;
    read_data_d        = read_data_q;

    case (state_q)
      IDLE: begin
        if (instr_eligible || data_eligible) begin
          last_grant_d = grant;
          if (grant == GRANT_DATA) begin
            state_d          = DATA;
            resp_instr_d     = 1'b0;
            mem_address_d    = bus.data_address;
            mem_write_data_d = bus.write_data;
            // Read+write together is illegal; the write takes precedence
            mem_write_d      = bus.data_memory_write;
            mem_read_d       = ~bus.data_memory_write;
          end else begin
            state_d       = INSTR;
            resp_instr_d  = 1'b1;
            mem_address_d = bus.instruction_address;
            mem_read_d    = 1'b1;
            mem_write_d   = 1'b0;
          end
        end
      end

      INSTR: begin
        if (bus.mem_ack) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (bus.flush_bus) begin
            // Flush coinciding with the ack: nothing left to drain
            state_d = IDLE;
          end else begin
            instruction_data_d = bus.mem_read_data;
            state_d            = RESP;
          end
        end else if (bus.flush_bus) begin
          // Memory cannot abort, so keep strobing and throw the data away
          state_d = DRAIN;
        end
      end

      DATA: begin
        if (bus.mem_ack) begin
          if (mem_read_q) begin
            read_data_d = bus.mem_read_data;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESP;
        end
      end

      DRAIN: begin
        if (bus.mem_ack) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = IDLE;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      last_grant_q       <= GRANT_INSTR;
      resp_instr_q       <= 1'b0;
      mem_read_q         <= 1'b0;
      mem_write_q        <= 1'b0;
      mem_address_q      <= 32'h0;
      mem_write_data_q   <= 32'h0;
      instruction_data_q <= 32'h0;
      read_data_q        <= 32'h0;
    end else begin
      state_q            <= state_d;
      last_grant_q       <= last_grant_d;
      resp_instr_q       <= resp_instr_d;
      mem_read_q         <= mem_read_d;
      mem_write_q        <= mem_write_d;
      mem_address_q      <= mem_address_d;
      mem_write_data_q   <= mem_write_data_d;
      instruction_data_q <= instruction_data_d;
      read_data_q        <= read_data_d;
    end
  end

  assign bus.mem_read             = mem_read_q;
  assign bus.mem_write            = mem_write_q;
  assign bus.mem_address          = mem_address_q;
  assign bus.mem_write_data       = mem_write_data_q;
  assign bus.instruction_data     = instruction_data_q;
  assign bus.read_data            = read_data_q;
  // A flush arriving in the response cycle still suppresses the fetch pulse
  assign bus.instruction_response = (state_q == RESP) & resp_instr_q & ~bus.flush_bus;
  assign bus.data_memory_response = (state_q == RESP) & ~resp_instr_q;

endmodule
`default_nettype wire

// File: tb/tb_core_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_bus_arbiter
// Description : Directed self-checking bench for core_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_bus_arbiter;
  import grande_risco5_types::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_idata = 32'h0;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clk = ~clk;

  core_bus_arbiter_if bus();

  core_bus_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.flush_bus           = 1'b0;
    bus.instruction_request = 1'b0;
    bus.instruction_address = 32'h0;
    bus.data_memory_read    = 1'b0;
    bus.data_memory_write   = 1'b0;
    bus.data_address        = 32'h0;
    bus.write_data          = 32'h0;
    bus.mem_ack             = 1'b0;
    bus.mem_read_data       = 32'h0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.instruction_response, bus.data_memory_response} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000",
        {bus.mem_read, bus.mem_write, bus.instruction_response, bus.data_memory_response});
    end
    checks++;
    if (bus.mem_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.mem_address); end
    checks++;
    if (bus.mem_write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.mem_write_data); end
    checks++;
    if (bus.read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.read_data); end
    checks++;
    if (bus.instruction_data !== 32'h0) begin errors++; $display("FAIL reset_idata: got %h expected 0", bus.instruction_data); end
    checks++;
    if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dut.state_q); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store;
    int pulses = 0;
    bus.data_memory_write = 1'b1;
    bus.data_address      = 32'h8000_0004;
    bus.write_data        = 32'hDEAD_BEEF;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_write_data} !== {2'b10, 32'h8000_0004, 32'hDEAD_BEEF}) begin
        errors++; $display("FAIL store_hold%0d: got w=%b r=%b a=%h d=%h expected w=1 r=0 a=80000004 d=deadbeef",
          i, bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_write_data);
      end
      if (bus.data_memory_response) pulses++;
      if (i == 3) bus.mem_ack = 1'b1;
      tick();
    end
    bus.mem_ack = 1'b0;
    checks++;
    if ({bus.data_memory_response, bus.mem_write} !== 2'b10) begin
      errors++; $display("FAIL store_resp: got resp=%b w=%b expected resp=1 w=0", bus.data_memory_response, bus.mem_write);
    end
    if (bus.data_memory_response) pulses++;
    bus.data_memory_write = 1'b0;
    tick();
    if (bus.data_memory_response) pulses++;
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL store_pulses: got %0d expected 1", pulses); end
    checks++;
    if (dut.state_q !== IDLE) begin errors++; $display("FAIL store_idle: got %0d expected IDLE", dut.state_q); end
    checks++;
    if (bus.read_data !== exp_rdata) begin errors++; $display("FAIL store_rdata_hold: got %h expected %h", bus.read_data, exp_rdata); end
  endtask

  task automatic test_fetch;
    int rd_cnt = 0;
    bus.instruction_request = 1'b1;
    bus.instruction_address = 32'h0000_0040;
    tick();
    if (bus.mem_read) rd_cnt++;
    checks++;
    if ({bus.mem_read, bus.mem_address, bus.instruction_response} !== {1'b1, 32'h40, 1'b0}) begin
      errors++; $display("FAIL fetch_issue: got r=%b a=%h resp=%b expected r=1 a=00000040 resp=0",
        bus.mem_read, bus.mem_address, bus.instruction_response);
    end
    tick();
    if (bus.mem_read) rd_cnt++;
    bus.mem_ack       = 1'b1;
    bus.mem_read_data = 32'h0000_0013;
    tick();
    bus.mem_ack = 1'b0;
    if (bus.mem_read) rd_cnt++;
    exp_idata = 32'h0000_0013;
    checks++;
    if ({bus.instruction_response, bus.instruction_data} !== {1'b1, exp_idata}) begin
      errors++; $display("FAIL fetch_resp: got resp=%b d=%h expected resp=1 d=%h",
        bus.instruction_response, bus.instruction_data, exp_idata);
    end
    bus.instruction_request = 1'b0;
    tick();
    if (bus.mem_read) rd_cnt++;
    checks++;
    if (rd_cnt !== 2) begin errors++; $display("FAIL fetch_strobe_len: got %0d expected 2", rd_cnt); end
    checks++;
    if ({bus.instruction_response, bus.instruction_data} !== {1'b0, exp_idata}) begin
      errors++; $display("FAIL fetch_after: got resp=%b d=%h expected resp=0 d=%h",
        bus.instruction_response, bus.instruction_data, exp_idata);
    end
  endtask

  task automatic test_contention;
    logic [31:0] iaddr = 32'h0000_0100;
    logic [31:0] daddr = 32'h0000_0200;
    logic [31:0] eaddr;
    bit exp_data[3];
`ifdef BUS_ARB_ROUND_ROBIN_EN
    exp_data = '{1'b1, 1'b0, 1'b1};
`else
    exp_data = '{1'b1, 1'b1, 1'b1};
`endif
    bus.instruction_request = 1'b1;
    bus.data_memory_read    = 1'b1;
    for (int r = 0; r < 3; r++) begin
      bus.instruction_address = iaddr;
      bus.data_address        = daddr;
      tick();
      eaddr = exp_data[r] ? daddr : iaddr;
      checks++;
      if ({bus.mem_read, bus.mem_address} !== {1'b1, eaddr}) begin
        errors++; $display("FAIL contend_grant%0d: got r=%b a=%h expected r=1 a=%h", r, bus.mem_read, bus.mem_address, eaddr);
      end
      bus.mem_ack       = 1'b1;
      bus.mem_read_data = eaddr ^ 32'hA5A5_0000;
      tick();
      bus.mem_ack = 1'b0;
      if (exp_data[r]) exp_rdata = eaddr ^ 32'hA5A5_0000;
      else             exp_idata = eaddr ^ 32'hA5A5_0000;
      checks++;
      if ({bus.instruction_response, bus.data_memory_response, bus.instruction_data, bus.read_data}
          !== {~exp_data[r], exp_data[r], exp_idata, exp_rdata}) begin
        errors++; $display("FAIL contend_resp%0d: got ir=%b dr=%b id=%h rd=%h expected ir=%b dr=%b id=%h rd=%h",
          r, bus.instruction_response, bus.data_memory_response, bus.instruction_data, bus.read_data,
          ~exp_data[r], exp_data[r], exp_idata, exp_rdata);
      end
      if (exp_data[r]) daddr = daddr + 32'd4;
      else             iaddr = iaddr + 32'd4;
      bus.instruction_address = iaddr;
      bus.data_address        = daddr;
      tick();
    end
    bus.instruction_request = 1'b0;
    bus.data_memory_read    = 1'b0;
    tick();
    checks++;
    if ({dut.state_q, bus.mem_read} !== {IDLE, 1'b0}) begin
      errors++; $display("FAIL contend_idle: got st=%0d r=%b expected IDLE r=0", dut.state_q, bus.mem_read);
    end
  endtask

  task automatic test_flush_fetch;
    bus.instruction_request = 1'b1;
    bus.instruction_address = 32'h0000_0300;
    tick();
    checks++;
    if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL flush_issue: got %b expected 1", bus.mem_read); end
    bus.flush_bus = 1'b1;
    tick();
    bus.flush_bus           = 1'b0;
    bus.instruction_request = 1'b0;
    checks++;
    if ({dut.state_q, bus.mem_read, bus.instruction_response} !== {DRAIN, 1'b1, 1'b0}) begin
      errors++; $display("FAIL flush_drain: got st=%0d r=%b resp=%b expected DRAIN r=1 resp=0",
        dut.state_q, bus.mem_read, bus.instruction_response);
    end
    tick();
    bus.mem_ack       = 1'b1;
    bus.mem_read_data = 32'h1234_5678;
    tick();
    bus.mem_ack = 1'b0;
    checks++;
    if ({dut.state_q, bus.mem_read, bus.instruction_response, bus.instruction_data} !== {IDLE, 1'b0, 1'b0, exp_idata}) begin
      errors++; $display("FAIL flush_discard: got st=%0d r=%b resp=%b d=%h expected IDLE r=0 resp=0 d=%h",
        dut.state_q, bus.mem_read, bus.instruction_response, bus.instruction_data, exp_idata);
    end
    bus.data_memory_read = 1'b1;
    bus.data_address     = 32'h0000_0400;
    tick();
    checks++;
    if ({bus.mem_read, bus.mem_address} !== {1'b1, 32'h400}) begin
      errors++; $display("FAIL flush_load_issue: got r=%b a=%h expected r=1 a=00000400", bus.mem_read, bus.mem_address);
    end
    bus.mem_ack       = 1'b1;
    bus.mem_read_data = 32'h0BAD_F00D;
    tick();
    bus.mem_ack = 1'b0;
    exp_rdata = 32'h0BAD_F00D;
    checks++;
    if ({bus.data_memory_response, bus.read_data} !== {1'b1, exp_rdata}) begin
      errors++; $display("FAIL flush_load_resp: got resp=%b d=%h expected resp=1 d=%h",
        bus.data_memory_response, bus.read_data, exp_rdata);
    end
    bus.data_memory_read = 1'b0;
    tick();
  endtask

  task automatic test_flush_same_cycle;
    bus.instruction_request = 1'b1;
    bus.instruction_address = 32'h0000_0600;
    bus.flush_bus           = 1'b1;
    tick();
    checks++;
    if ({dut.state_q, bus.mem_read} !== {IDLE, 1'b0}) begin
      errors++; $display("FAIL same_flush_block: got st=%0d r=%b expected IDLE r=0", dut.state_q, bus.mem_read);
    end
    bus.flush_bus = 1'b0;
    tick();
    checks++;
    if ({bus.mem_read, bus.mem_address} !== {1'b1, 32'h600}) begin
      errors++; $display("FAIL same_flush_issue: got r=%b a=%h expected r=1 a=00000600", bus.mem_read, bus.mem_address);
    end
    bus.mem_ack       = 1'b1;
    bus.mem_read_data = 32'h0000_0077;
    tick();
    bus.mem_ack = 1'b0;
    exp_idata = 32'h0000_0077;
    checks++;
    if ({bus.instruction_response, bus.instruction_data} !== {1'b1, exp_idata}) begin
      errors++; $display("FAIL same_flush_resp: got resp=%b d=%h expected resp=1 d=%h",
        bus.instruction_response, bus.instruction_data, exp_idata);
    end
    bus.flush_bus = 1'b1;
    #1;
    checks++;
    if (bus.instruction_response !== 1'b0) begin
      errors++; $display("FAIL resp_flush_mask: got %b expected 0", bus.instruction_response);
    end
    bus.flush_bus           = 1'b0;
    bus.instruction_request = 1'b0;
    tick();
  endtask

  task automatic test_rw_conflict;
    bus.data_memory_read  = 1'b1;
    bus.data_memory_write = 1'b1;
    bus.data_address      = 32'h0000_0700;
    bus.write_data        = 32'h0000_00AB;
    tick();
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.mem_write_data} !== {2'b01, 32'hAB}) begin
      errors++; $display("FAIL rw_conflict: got r=%b w=%b d=%h expected r=0 w=1 d=000000ab",
        bus.mem_read, bus.mem_write, bus.mem_write_data);
    end
    bus.mem_ack       = 1'b1;
    bus.mem_read_data = 32'hFFFF_FFFF;
    tick();
    bus.mem_ack = 1'b0;
    checks++;
    if ({bus.data_memory_response, bus.read_data} !== {1'b1, exp_rdata}) begin
      errors++; $display("FAIL rw_conflict_resp: got resp=%b d=%h expected resp=1 d=%h",
        bus.data_memory_response, bus.read_data, exp_rdata);
    end
    bus.data_memory_read  = 1'b0;
    bus.data_memory_write = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    bus.data_memory_write = 1'b1;
    bus.data_address      = 32'h0000_0500;
    bus.write_data        = 32'h0000_0001;
    tick();
    checks++;
    if ({dut.state_q, bus.mem_write} !== {DATA, 1'b1}) begin
      errors++; $display("FAIL rstmid_data: got st=%0d w=%b expected DATA w=1", dut.state_q, bus.mem_write);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.data_memory_write = 1'b0;
    exp_idata = 32'h0;
    exp_rdata = 32'h0;
    checks++;
    if ({dut.state_q, bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_write_data, bus.read_data, bus.instruction_data}
        !== {IDLE, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0}) begin
      errors++; $display("FAIL rstmid_clear: got st=%0d r=%b w=%b a=%h wd=%h rd=%h id=%h expected all zero and IDLE",
        dut.state_q, bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_write_data, bus.read_data, bus.instruction_data);
    end
    bus.mem_ack       = 1'b1;
    bus.mem_read_data = 32'hCAFE_CAFE;
    tick();
    bus.mem_ack = 1'b0;
    checks++;
    if ({dut.state_q, bus.data_memory_response, bus.instruction_response, bus.read_data} !== {IDLE, 2'b00, 32'h0}) begin
      errors++; $display("FAIL rstmid_late_ack: got st=%0d dr=%b ir=%b rd=%h expected IDLE 0 0 00000000",
        dut.state_q, bus.data_memory_response, bus.instruction_response, bus.read_data);
    end
    tick();
    checks++;
    if ({bus.data_memory_response, bus.instruction_response} !== 2'b00) begin
      errors++; $display("FAIL rstmid_no_resp: got %b expected 00", {bus.data_memory_response, bus.instruction_response});
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_fetch();
    test_contention();
    test_flush_fetch();
    test_flush_same_cycle();
    test_rw_conflict();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
